fifo_rr_arbiter: RTL and testbench

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

---
 rtl/fifo_rr_arbiter.sv | 103 ++++++++++
 tb/tb_fifo_rr_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - packet-locked round-robin arbiter feeding one registered output stream
`timescale 1ns/1ps

module fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_REQ-1:0]              in_valid,
  input  logic [NUM_REQ-1:0]              in_last,
  output logic [NUM_REQ-1:0]              in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
  output logic                            busy
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         sel;
  logic [IW-1:0]         cand;
  logic                  any_valid;
  logic                  out_free;
  logic                  xfer;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  // Scan from the far end back so the candidate closest after ptr wins last.
  always_comb begin
    sel       = ptr;
    cand      = ptr;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (in_valid[cand]) begin
        sel       = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign out_free = !out_valid || out_ready;
  assign busy     = (state == LOCKED);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    in_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last    = in_last[i];
        in_ready[i] = (state == LOCKED) && out_free;
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= IW'(NUM_REQ - 1);
      grant_idx <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_idx <= sel;
            state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && sel_last) begin
            state <= IDLE;
            ptr   <= grant_idx;
          end
        end
        default: state <= IDLE;
      endcase

      if (xfer) begin
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed vector table plus stall, self-wrap and reset sequences
`timescale 1ns/1ps

module tb_fifo_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  grant_idx;
  logic        busy;

  int checks;
  int failures;

  fifo_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        rdy;
    logic        e_ov;
    logic [7:0]  e_d;
    logic        e_l;
    logic [1:0]  e_g;
    logic        e_busy;
    logic [3:0]  e_ir;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic rd);
    @(negedge clk);
    rst = r; in_valid = v; in_last = l; in_data = d; out_ready = rd;
    #1;
  endtask

  logic [7:0] rd_q[$];
  logic       rl_q[$];
  logic [7:0] frozen;
  logic [7:0] beat;
  int         bi;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;

    // Four all-valid single-beat requesters, then a 3-beat packet from 2 while 1 waits.
    tbl.push_back(vec_t'{0, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 0, 2'd0, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 0, 2'd0, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 0, 2'd0, 1, 4'h1});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 1, 8'h10, 1, 2'd0, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 0, 2'd1, 1, 4'h2});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 1, 8'h11, 1, 2'd1, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 0, 2'd2, 1, 4'h4});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 1, 8'h12, 1, 2'd2, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 0, 2'd3, 1, 4'h8});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 1, 8'h13, 1, 2'd3, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 0, 2'd0, 1, 4'h1});
    tbl.push_back(vec_t'{1, 4'h0, 4'h0, 32'h00000000, 1, 1, 8'h10, 1, 2'd0, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'h0, 4'h0, 32'h00000000, 1, 0, 8'h00, 0, 2'd0, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'h4, 4'h0, 32'h00A10000, 1, 0, 8'h00, 0, 2'd0, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'h6, 4'h2, 32'h00A15500, 1, 0, 8'h00, 0, 2'd2, 1, 4'h4});
    tbl.push_back(vec_t'{1, 4'h6, 4'h2, 32'h00A25500, 1, 1, 8'hA1, 0, 2'd2, 1, 4'h4});
    tbl.push_back(vec_t'{1, 4'h6, 4'h6, 32'h00A35500, 1, 1, 8'hA2, 0, 2'd2, 1, 4'h4});
    tbl.push_back(vec_t'{1, 4'h2, 4'h2, 32'h00005500, 1, 1, 8'hA3, 1, 2'd2, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'h2, 4'h2, 32'h00005500, 1, 0, 8'h00, 0, 2'd1, 1, 4'h2});
    tbl.push_back(vec_t'{1, 4'h0, 4'h0, 32'h00000000, 1, 1, 8'h55, 1, 2'd1, 0, 4'h0});
    tbl.push_back(vec_t'{1, 4'h0, 4'h0, 32'h00000000, 1, 0, 8'h00, 0, 2'd1, 0, 4'h0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].rdy);
      check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("vec%0d_grant_idx", i), grant_idx, tbl[i].e_g);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
      if (tbl[i].e_ov || !tbl[i].r) begin
        check($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_d);
        check($sformatf("vec%0d_out_last", i), out_last, tbl[i].e_l);
      end
    end

    // Self-wrap: ptr=1, only requester 3 valid, granted twice with one bubble between.
    step(1, 4'h8, 4'h8, 32'hC3000000, 1);
    check("wrap_idle_busy", busy, 0);
    step(1, 4'h8, 4'h8, 32'hC3000000, 1);
    check("wrap_grant1", grant_idx, 3);
    check("wrap_ready1", in_ready, 4'h8);
    step(1, 4'h8, 4'h8, 32'hC4000000, 1);
    check("wrap_bubble_busy", busy, 0);
    check("wrap_out1", out_data, 8'hC3);
    step(1, 4'h8, 4'h8, 32'hC4000000, 1);
    check("wrap_grant2", grant_idx, 3);
    check("wrap_busy2", busy, 1);
    check("wrap_ready2", in_ready, 4'h8);
    step(1, 4'h0, 4'h0, 32'h00000000, 1);
    check("wrap_out2_valid", out_valid, 1);
    check("wrap_out2", out_data, 8'hC4);

    // Backpressure: 4-beat packet from requester 0 with out_ready low for 5 cycles.
    bi = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rst = 1'b1;
      out_ready = !(c >= 4 && c < 9);
      beat = 8'hB0 + 8'(bi);
      in_valid = (bi < 4) ? 4'h1 : 4'h0;
      in_last = (bi == 3) ? 4'h1 : 4'h0;
      in_data = {24'h0, beat};
      #1;
      if (c == 4) frozen = out_data;
      if (c >= 4 && c < 9) begin
        check($sformatf("stall%0d_valid", c), out_valid, 1);
        check($sformatf("stall%0d_in_ready", c), in_ready, 4'h0);
        if (c > 4) check($sformatf("stall%0d_data", c), out_data, frozen);
      end
      if (out_valid && out_ready) begin
        rd_q.push_back(out_data);
        rl_q.push_back(out_last);
      end
      if (in_valid[0] && in_ready[0]) bi++;
    end
    check("stall_frozen_value", frozen, 8'hB2);
    check("stall_beat_count", rd_q.size(), 4);
    for (int k = 0; k < rd_q.size() && k < 4; k++) begin
      check($sformatf("stall_beat%0d_data", k), rd_q[k], 8'hB0 + 8'(k));
      check($sformatf("stall_beat%0d_last", k), rl_q[k], (k == 3));
    end

    // Reset mid-packet abandons everything; fresh arbitration picks requester 1.
    step(1, 4'h4, 4'h0, 32'h00D00000, 1);
    check("rst_pre_busy", busy, 0);
    step(1, 4'h4, 4'h0, 32'h00D00000, 1);
    check("rst_pre_grant", grant_idx, 2);
    step(1, 4'h4, 4'h0, 32'h00D10000, 1);
    check("rst_pre_out", out_data, 8'hD0);
    step(1, 4'h4, 4'h0, 32'h00D20000, 1);
    check("rst_pre_out2", out_data, 8'hD1);
    check("rst_pre_busy2", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_ready", in_ready, 4'h0);
    check("rst_async_grant", grant_idx, 0);
    check("rst_async_data", out_data, 8'h00);
    step(0, 4'h2, 4'h0, 32'h0000E000, 1);
    check("rst_held_busy", busy, 0);
    step(1, 4'h2, 4'h0, 32'h0000E000, 1);
    check("rst_rel_idle", busy, 0);
    step(1, 4'h2, 4'h0, 32'h0000E000, 1);
    check("rst_new_grant", grant_idx, 1);
    check("rst_new_ready", in_ready, 4'h2);
    step(1, 4'h2, 4'h2, 32'h0000E100, 1);
    check("rst_new_beat0", out_data, 8'hE0);
    check("rst_new_last0", out_last, 0);
    step(1, 4'h0, 4'h0, 32'h00000000, 1);
    check("rst_new_beat1", out_data, 8'hE1);
    check("rst_new_last1", out_last, 1);
    check("rst_new_valid1", out_valid, 1);
    check("rst_new_done", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
